voice_allocator: RTL and testbench

- Polyphonic voice allocator between the SPI command decoder and the 8-voice oscillator bank.
- Accepts note-on/note-off events carrying a 16-bit pitch divider and owns the per-voice divider registers that drive the oscillators.
- Picks a voice per event: retrigger, first free voice, or steal.
- A sequential scan FSM examines one voice per cycle, which keeps the comparator logic to a single shared 16-bit compare.

---
 rtl/voice_allocator.sv | 236 +++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger / first-free / steal, one voice examined per scan cycle.
// Optional `VOICE_ALLOC_LRU_EN replaces the round-robin steal pointer with per-voice age tracking.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int VID_W      = 3,
  parameter int D_W        = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      evt_valid,
  output logic                      evt_ready,
  input  logic                      evt_is_on,
  input  logic [D_W-1:0]            evt_div,
  input  logic                      panic,
  output logic [NUM_VOICES*D_W-1:0] voice_div,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic                      alloc_valid,
  output logic [VID_W-1:0]          alloc_voice,
  output logic                      alloc_steal
);

  // state | meaning
  // IDLE   | ready for an event; alloc_valid pulses here after a commit
  // SCAN   | examine one voice per cycle for match / free (/ oldest)
  // COMMIT | apply retrigger, allocate, steal or release
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [D_W-1:0]   div_q [NUM_VOICES];
  logic [D_W-1:0]   div_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic             is_on_q, is_on_d;
  logic [D_W-1:0]   ldiv_q, ldiv_d;
  logic [VID_W-1:0] scan_idx_q, scan_idx_d;
  logic             match_found_q, match_found_d;
  logic [VID_W-1:0] match_idx_q, match_idx_d;
  logic             free_found_q, free_found_d;
  logic [VID_W-1:0] free_idx_q, free_idx_d;
  logic             alloc_valid_q, alloc_valid_d;
  logic [VID_W-1:0] alloc_voice_q, alloc_voice_d;
  logic             alloc_steal_q, alloc_steal_d;
  logic             accept;
  logic [VID_W-1:0] tgt;
  logic [VID_W-1:0] victim;
`ifdef VOICE_ALLOC_LRU_EN
  logic [VID_W-1:0] age_q [NUM_VOICES];
  logic [VID_W-1:0] age_d [NUM_VOICES];
  logic [VID_W-1:0] oldest_idx_q, oldest_idx_d;
  logic [VID_W-1:0] oldest_age_q, oldest_age_d;
  logic [VID_W-1:0] old_age;
`else
  logic [VID_W-1:0] steal_ptr_q, steal_ptr_d;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      for (int i = 0; i < NUM_VOICES; i++) div_q[i] <= '0;
      active_q      <= '0;
      is_on_q       <= 1'b0;
      ldiv_q        <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      alloc_valid_q <= 1'b0;
      alloc_voice_q <= '0;
      alloc_steal_q <= 1'b0;
`ifdef VOICE_ALLOC_LRU_EN
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= VID_W'(i);
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
`else
      steal_ptr_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      active_q      <= active_d;
      is_on_q       <= is_on_d;
      ldiv_q        <= ldiv_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_voice_q <= alloc_voice_d;
      alloc_steal_q <= alloc_steal_d;
`ifdef VOICE_ALLOC_LRU_EN
      age_q         <= age_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
`else
      steal_ptr_q   <= steal_ptr_d;
`endif
    end
  end

  always_comb begin
    evt_ready = (state_q == IDLE) && !panic;
    accept    = evt_valid && evt_ready;
  end

  always_comb begin
    state_d = state_q;
    if (panic) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && !(evt_is_on && evt_div == '0)) state_d = SCAN;
        SCAN:    if (scan_idx_q == VID_W'(NUM_VOICES-1)) state_d = COMMIT;
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef VOICE_ALLOC_LRU_EN
  assign victim = oldest_idx_q;
`else
  assign victim = steal_ptr_q;
`endif

  always_comb begin
    div_d         = div_q;
    active_d      = active_q;
    is_on_d       = is_on_q;
    ldiv_d        = ldiv_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    alloc_valid_d = 1'b0;
    alloc_voice_d = alloc_voice_q;
    alloc_steal_d = alloc_steal_q;
    tgt           = victim;
`ifdef VOICE_ALLOC_LRU_EN
    age_d         = age_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    old_age       = '0;
`else
    steal_ptr_d   = steal_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          is_on_d       = evt_is_on;
          ldiv_d        = evt_div;
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
        end
      end
      SCAN: begin
        if (active_q[scan_idx_q] && div_q[scan_idx_q] == ldiv_q && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        if (!active_q[scan_idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
`ifdef VOICE_ALLOC_LRU_EN
        // strict compare keeps the lowest index on ties
        if (scan_idx_q == '0 || age_q[scan_idx_q] > oldest_age_q) begin
          oldest_idx_d = scan_idx_q;
          oldest_age_d = age_q[scan_idx_q];
        end
`endif
        scan_idx_d = scan_idx_q + VID_W'(1);
      end
      COMMIT: begin
        if (is_on_q) begin
          alloc_valid_d = 1'b1;
          alloc_steal_d = 1'b0;
          if (match_found_q) begin
            tgt = match_idx_q;
          end else if (free_found_q) begin
            tgt = free_idx_q;
          end else begin
            tgt           = victim;
            alloc_steal_d = 1'b1;
`ifndef VOICE_ALLOC_LRU_EN
            steal_ptr_d   = steal_ptr_q + VID_W'(1);
`endif
          end
          div_d[tgt]    = ldiv_q;
          active_d[tgt] = 1'b1;
          alloc_voice_d = tgt;
`ifdef VOICE_ALLOC_LRU_EN
          old_age = age_q[tgt];
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (VID_W'(i) == tgt)     age_d[i] = '0;
            else if (age_q[i] < old_age) age_d[i] = age_q[i] + VID_W'(1);
          end
`endif
        end else if (match_found_q) begin
          tgt           = match_idx_q;
          div_d[tgt]    = '0;
          active_d[tgt] = 1'b0;
          alloc_valid_d = 1'b1;
          alloc_voice_d = tgt;
          alloc_steal_d = 1'b0;
        end
      end
      default: ;
    endcase
    // panic wins over everything, including a commit in the same cycle
    if (panic) begin
      for (int i = 0; i < NUM_VOICES; i++) div_d[i] = '0;
      active_d      = '0;
      alloc_valid_d = 1'b0;
      alloc_voice_d = alloc_voice_q;
      alloc_steal_d = alloc_steal_q;
`ifdef VOICE_ALLOC_LRU_EN
      age_d         = age_q;
`else
      steal_ptr_d   = steal_ptr_q;
`endif
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_div
    assign voice_div[i*D_W +: D_W] = div_q[i];
  end

  assign voice_active = active_q;
  assign alloc_valid  = alloc_valid_q;
  assign alloc_voice  = alloc_voice_q;
  assign alloc_steal  = alloc_steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (default build, round-robin stealing).
module tb_voice_allocator;
  localparam int NV = 8;
  localparam int VW = 3;
  localparam int DW = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              evt_valid = 1'b0;
  logic              evt_ready;
  logic              evt_is_on = 1'b0;
  logic [DW-1:0]     evt_div = '0;
  logic              panic = 1'b0;
  logic [NV*DW-1:0]  voice_div;
  logic [NV-1:0]     voice_active;
  logic              alloc_valid;
  logic [VW-1:0]     alloc_voice;
  logic              alloc_steal;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_div [NV];
  logic [NV-1:0] exp_act;

  voice_allocator #(.NUM_VOICES(NV), .VID_W(VW), .D_W(DW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_is_on(evt_is_on), .evt_div(evt_div),
    .panic(panic), .voice_div(voice_div), .voice_active(voice_active),
    .alloc_valid(alloc_valid), .alloc_voice(alloc_voice), .alloc_steal(alloc_steal)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_vec();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NV; i++) v[i*DW +: DW] = exp_div[i];
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NV; i++) exp_div[i] = '0;
    exp_act = '0;
  endtask

  task automatic start_evt(input logic on, input logic [DW-1:0] d);
    evt_is_on = on;
    evt_div   = d;
    evt_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    evt_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge sys_clk);
      #1;
      if (alloc_valid) seen = 1'b1;
      if (evt_ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_on(input string tag, input logic [DW-1:0] d, input int v, input logic stl);
    int   lat;
    logic seen;
    start_evt(1'b1, d);
    wait_done(lat, seen);
    exp_div[v] = d;
    exp_act[v] = 1'b1;
    check({tag, "_lat"}, 128'(lat), 128'd9);
    check({tag, "_valid"}, 128'(seen), 128'd1);
    check({tag, "_voice"}, 128'(alloc_voice), 128'(v));
    check({tag, "_steal"}, 128'(alloc_steal), 128'(stl));
    check({tag, "_div"}, voice_div, exp_vec());
    check({tag, "_act"}, 128'(voice_active), 128'(exp_act));
  endtask

  task automatic run_off(input string tag, input logic [DW-1:0] d, input int v);
    int   lat;
    logic seen;
    start_evt(1'b0, d);
    wait_done(lat, seen);
    exp_div[v] = '0;
    exp_act[v] = 1'b0;
    check({tag, "_lat"}, 128'(lat), 128'd9);
    check({tag, "_valid"}, 128'(seen), 128'd1);
    check({tag, "_voice"}, 128'(alloc_voice), 128'(v));
    check({tag, "_steal"}, 128'(alloc_steal), 128'd0);
    check({tag, "_div"}, voice_div, exp_vec());
    check({tag, "_act"}, 128'(voice_active), 128'(exp_act));
  endtask

  initial begin
    int   lat;
    logic seen;
    clear_model();
    #12;
    check("rst_div", voice_div, 128'd0);
    check("rst_act", 128'(voice_active), 128'd0);
    check("rst_valid", 128'(alloc_valid), 128'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    #1;
    check("rst_ready", 128'(evt_ready), 128'd1);

    run_on("first", 16'h1234, 0, 1'b0);
    run_on("retrig", 16'h1234, 0, 1'b0);
    for (int i = 1; i <= 7; i++) run_on("fill", DW'(i * 256), i, 1'b0);
    run_off("off3", 16'h0300, 3);
    run_on("reuse3", 16'h0900, 3, 1'b0);

    run_on("steal0", 16'h0A00, 0, 1'b1);
    run_on("steal1", 16'h0B00, 1, 1'b1);
    for (int k = 0; k < 8; k++) run_on("steal_rr", DW'(16'h0C00 + k * 256), (2 + k) % 8, 1'b1);
    run_on("steal_wrap", 16'h1400, 2, 1'b1);
    run_on("retrig_full", 16'h1300, 1, 1'b0);

    start_evt(1'b0, 16'h5555);
    wait_done(lat, seen);
    check("offnm_lat", 128'(lat), 128'd9);
    check("offnm_valid", 128'(seen), 128'd0);
    check("offnm_div", voice_div, exp_vec());
    check("offnm_act", 128'(voice_active), 128'(exp_act));

    start_evt(1'b1, 16'h0000);
    check("div0_ready", 128'(evt_ready), 128'd1);
    wait_done(lat, seen);
    check("div0_lat", 128'(lat), 128'd1);
    check("div0_valid", 128'(seen), 128'd0);
    check("div0_div", voice_div, exp_vec());

    // panic during the fourth scan cycle of a note-on
    start_evt(1'b1, 16'h2000);
    repeat (3) @(posedge sys_clk);
    #1;
    panic = 1'b1;
    @(posedge sys_clk);
    #1;
    clear_model();
    check("pscan_div", voice_div, 128'd0);
    check("pscan_act", 128'(voice_active), 128'd0);
    check("pscan_ready", 128'(evt_ready), 128'd0);
    check("pscan_valid", 128'(alloc_valid), 128'd0);
    panic = 1'b0;
    #1;
    check("pscan_idle", 128'(evt_ready), 128'd1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge sys_clk);
      #1;
      if (alloc_valid) seen = 1'b1;
    end
    check("pscan_novalid", 128'(seen), 128'd0);

    // event offered while panic held in IDLE must be refused
    panic = 1'b1;
    evt_is_on = 1'b1;
    evt_div = 16'h2100;
    evt_valid = 1'b1;
    #1;
    check("pidle_ready", 128'(evt_ready), 128'd0);
    @(posedge sys_clk);
    #1;
    evt_valid = 1'b0;
    panic = 1'b0;
    #1;
    check("pidle_notaken", 128'(evt_ready), 128'd1);
    check("pidle_act", 128'(voice_active), 128'd0);

    // steal pointer survives panic: next steal lands on voice 3
    for (int i = 0; i < 8; i++) run_on("refill", DW'((i + 1) * 256), i, 1'b0);
    run_on("steal_after_panic", 16'h0900, 3, 1'b1);

    // reset in the middle of a scan
    start_evt(1'b1, 16'h3000);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("rscan_div", voice_div, 128'd0);
    check("rscan_act", 128'(voice_active), 128'd0);
    check("rscan_valid", 128'(alloc_valid), 128'd0);
    check("rscan_voice", 128'(alloc_voice), 128'd0);
    check("rscan_steal", 128'(alloc_steal), 128'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    #1;
    clear_model();
    check("rscan_ready", 128'(evt_ready), 128'd1);
    run_on("post_rst", 16'h1234, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
